// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and scan_sequencer.
// The skip_mask signal exists only when SCAN_SEQ_SKIP_EN is defined.
interface scan_sequencer_if #(
    parameter int N       = 2,
    parameter int M       = 3,
    parameter int DWELL_W = 8
) ();
    logic               start;
    logic               stop;
    logic               one_shot;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] blank;
    logic [N-1:0]       addr;
    logic               ena;
    logic               busy;
    logic               wrap;
    logic               done;
`ifdef SCAN_SEQ_SKIP_EN
    logic [M-1:0]       skip_mask;
`endif

    modport master (
        output start, stop, one_shot, dwell, blank,
`ifdef SCAN_SEQ_SKIP_EN
        output skip_mask,
`endif
        input  addr, ena, busy, wrap, done
    );

    modport slave (
        input  start, stop, one_shot, dwell, blank,
`ifdef SCAN_SEQ_SKIP_EN
        input  skip_mask,
`endif
        output addr, ena, busy, wrap, done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Channel-scan sequencer producing addr/ena for a one-hot decoder, with per-channel
// dwell and blanking gap. Define SCAN_SEQ_SKIP_EN to enable the skip_mask channel filter.
module scan_sequencer #(
    parameter int N       = 2,
    parameter int M       = 3,
    parameter int DWELL_W = 8
) (
    input logic            clk,
    input logic            rst,
    scan_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic               one_shot_q;
    logic [N-1:0]       addr_q;
    logic               ena_q, busy_q, wrap_q, done_q;

    logic [M-1:0]       mask;
    logic [N-1:0]       first_idx, higher_idx, adv_next;
    logic               has_higher, all_masked, adv_end, adv_wrap, expire;
    logic [DWELL_W-1:0] dwell_eff;

`ifdef SCAN_SEQ_SKIP_EN
    assign mask = bus.skip_mask;
`else
    assign mask = '0;
`endif

    // Lowest unmasked channel, and lowest unmasked channel above the current one.
    always_comb begin
        first_idx  = '0;
        higher_idx = '0;
        has_higher = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                first_idx = N'(i);
                if (i > int'(addr_q)) begin
                    higher_idx = N'(i);
                    has_higher = 1'b1;
                end
            end
        end
    end

    assign all_masked = &mask;
    assign adv_end    = all_masked || (!has_higher && one_shot_q);
    assign adv_next   = has_higher ? higher_idx : first_idx;
    assign adv_wrap   = (adv_next <= addr_q);
    assign dwell_eff  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign expire     = (cnt == DWELL_W'(1)) &&
                        ((state == BLANK) || (state == ACTIVE && bus.blank == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            one_shot_q <= 1'b0;
            addr_q     <= '0;
            ena_q      <= 1'b0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.stop) begin
                state  <= IDLE;
                addr_q <= '0;
                ena_q  <= 1'b0;
                busy_q <= 1'b0;
            end else if (state == IDLE) begin
                if (bus.start && !all_masked) begin
                    state      <= ACTIVE;
                    addr_q     <= first_idx;
                    one_shot_q <= bus.one_shot;
                    ena_q      <= 1'b1;
                    busy_q     <= 1'b1;
                    cnt        <= dwell_eff;
                end
            end else if (state == ACTIVE && cnt == DWELL_W'(1) && bus.blank != '0) begin
                state <= BLANK;
                ena_q <= 1'b0;
                cnt   <= bus.blank;
            end else if (expire) begin
                // Advance: either finish the sweep or move to the next channel.
                if (adv_end) begin
                    state  <= IDLE;
                    addr_q <= '0;
                    ena_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= one_shot_q;
                end else begin
                    state  <= ACTIVE;
                    addr_q <= adv_next;
                    wrap_q <= adv_wrap;
                    ena_q  <= 1'b1;
                    cnt    <= dwell_eff;
                end
            end else begin
                cnt <= cnt - DWELL_W'(1);
            end
        end
    end

    assign bus.addr = addr_q;
    assign bus.ena  = ena_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: a timeline-based reference model pushes the
// expected outputs for every clock; a negedge monitor pops and compares.
module tb_scan_sequencer;
    localparam int N       = 2;
    localparam int M       = 3;
    localparam int DWELL_W = 8;

    typedef struct packed {
        logic [N-1:0] addr;
        logic         ena;
        logic         busy;
        logic         wrap;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_sequencer_if #(.N(N), .M(M), .DWELL_W(DWELL_W)) bus ();

    scan_sequencer #(.N(N), .M(M), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t         q[$];
    int           checks = 0;
    int           passed = 0;
    int           cyc    = 0;

    // Reference model state: a scan is a timeline measured from the start edge.
    bit           run_m = 0;
    bit           os_m  = 0;
    int           t_m, dl_m, b_m;
    logic [N-1:0] chans[$];

    function automatic exp_t read_dut();
        exp_t a;
        a.addr = bus.addr;
        a.ena  = bus.ena;
        a.busy = bus.busy;
        a.wrap = bus.wrap;
        a.done = bus.done;
        return a;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s (cycle %0d): got addr=%0d ena=%b busy=%b wrap=%b done=%b, required addr=%0d ena=%b busy=%b wrap=%b done=%b",
                      name, cyc, act.addr, act.ena, act.busy, act.wrap, act.done,
                      req.addr, req.ena, req.busy, req.wrap, req.done);
    endtask

    function automatic logic [M-1:0] cur_mask();
`ifdef SCAN_SEQ_SKIP_EN
        return bus.skip_mask;
`else
        return '0;
`endif
    endfunction

    task automatic model_update(input bit s, input bit p);
        exp_t         e;
        logic [M-1:0] m;
        int           per, len, ch, pos;
        e = '0;
        if (rst || p) begin
            run_m = 0;
        end else if (!run_m) begin
            if (s) begin
                m = cur_mask();
                chans.delete();
                for (int i = 0; i < M; i++) if (!m[i]) chans.push_back(N'(i));
                if (chans.size() > 0) begin
                    run_m = 1;
                    t_m   = 0;
                    os_m  = bus.one_shot;
                    dl_m  = (bus.dwell == 0) ? 1 : int'(bus.dwell);
                    b_m   = int'(bus.blank);
                end
            end
        end else begin
            t_m++;
        end
        if (run_m) begin
            per = dl_m + b_m;
            len = chans.size();
            if (os_m && t_m == len * per) begin
                e.done = 1'b1;
                run_m  = 0;
            end else begin
                ch     = t_m / per;
                pos    = t_m % per;
                e.addr = chans[ch % len];
                e.ena  = (pos < dl_m);
                e.busy = 1'b1;
                e.wrap = (t_m > 0) && (pos == 0) && (ch % len == 0);
            end
        end
        q.push_back(e);
    endtask

    task automatic step(input bit s, input bit p);
        bus.start = s;
        bus.stop  = p;
        @(posedge clk);
        model_update(s, p);
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic config_scan(input int d, input int b, input bit os);
        bus.dwell    = DWELL_W'(d);
        bus.blank    = DWELL_W'(b);
        bus.one_shot = os;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) check("cycle", read_dut(), q.pop_front());
    end

    initial begin
        exp_t zero;
        zero = '0;
        bus.start = 0; bus.stop = 0;
        config_scan(4, 2, 0);
`ifdef SCAN_SEQ_SKIP_EN
        bus.skip_mask = '0;
`endif
        idle_steps(3);
        rst = 1'b0;
        idle_steps(2);

        // Continuous scan, wrap every 18 cycles.
        step(1'b1, 1'b0);
        idle_steps(40);
        step(1'b0, 1'b1);

        // One-shot sweep with dwell 1, no blanking.
        config_scan(1, 0, 1);
        step(1'b1, 1'b0);
        idle_steps(6);

        // Zero dwell treated as one.
        config_scan(0, 1, 0);
        step(1'b1, 1'b0);
        idle_steps(10);
        step(1'b0, 1'b1);

        // Stop in the second ACTIVE cycle of channel 1, then start+stop while idle.
        config_scan(4, 2, 1);
        step(1'b1, 1'b0);
        idle_steps(7);
        step(1'b0, 1'b1);
        idle_steps(2);
        step(1'b1, 1'b1);
        idle_steps(2);

        // Ignored start while busy, then async reset during BLANK.
        config_scan(4, 2, 0);
        step(1'b1, 1'b0);
        idle_steps(2);
        step(1'b1, 1'b0);
        idle_steps(2);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_reset", read_dut(), zero);
        step(1'b0, 1'b0);
        rst = 1'b0;
        idle_steps(2);

`ifdef SCAN_SEQ_SKIP_EN
        config_scan(1, 1, 0);
        bus.skip_mask = 3'b010;
        step(1'b1, 1'b0);
        idle_steps(12);
        step(1'b0, 1'b1);
        bus.skip_mask = 3'b111;
        step(1'b1, 1'b0);
        idle_steps(3);
`endif

        // Randomized scans; configuration only changes while idle.
        for (int it = 0; it < 25; it++) begin
            config_scan($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
`ifdef SCAN_SEQ_SKIP_EN
            bus.skip_mask = M'($urandom_range(0, (1 << M) - 1));
`endif
            step(1'b1, 1'b0);
            for (int c = 0; c < int'($urandom_range(5, 40)); c++)
                step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
            step(1'b0, 1'b1);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Registered channel-scan sequencer that generates the `addr`/`ena` pair consumed directly by the one-hot `decoder` stage, with the same `N` and `M` parameters. It walks channels 0..M-1 in order, holds each for a programmable dwell time, and inserts a programmable blanking gap with `ena` low between channels. Typical uses are display digit multiplexing, keypad row scanning and chip-select rotation. It runs continuously or as a single sweep.

## Interface
- `N`, default 2: address width; matches the decoder's `N`.
- `M`, default 3: number of channels; must satisfy 1 ≤ M ≤ 2^N.
- `DWELL_W`, default 8: width of the dwell and blank counters.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  start a scan; sampled only in IDLE.
- `stop`  in  1  abort the scan; sampled in any state.
- `one_shot`  in  1  sampled together with an accepted `start`. 1 = stop after a single sweep; 0 = run continuously.
- `dwell`  in  DWELL_W  length of the ACTIVE phase in cycles; 0 is treated as 1.
- `blank`  in  DWELL_W  length of the BLANK phase in cycles; 0 means no BLANK phase.
- `addr`  out  N  current channel; drives the decoder's `addr`.
- `ena`  out  1  channel enable; drives the decoder's `ena`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `wrap`  out  1  one-cycle pulse when `addr` returns to the first channel.
- `done`  out  1  one-cycle pulse when a one-shot sweep completes.
- `skip_mask`  in  M  present only with `SCAN_SEQ_SKIP_EN`; bit i = 1 skips channel i.

## Operation
- All outputs are registered. Reset values: `addr` = 0, `ena` = 0, `busy` = 0, `wrap` = 0, `done` = 0; FSM in IDLE.
- FSM states: IDLE, ACTIVE, BLANK.
- **IDLE**
  - `ena` = 0 and `addr` = 0.
  - On `start` with `stop` low: load the first channel into `addr`, latch `one_shot`, go to ACTIVE.
- **ACTIVE**
  - `ena` = 1. The counter is loaded with max(`dwell`, 1) on entry.
  - When the counter expires: go to BLANK if `blank` ≠ 0, otherwise advance.
- **BLANK**
  - `ena` = 0. The counter is loaded with `blank` on entry.
  - When the counter expires: advance.
- **Advance**
  - If `addr` is the last channel and one-shot is latched: go to IDLE, pulse `done`, set `addr` = 0.
  - Otherwise: set `addr` to the next channel, wrapping from M-1 to 0, and enter ACTIVE.
  - `wrap` pulses in the same cycle that `addr` takes the wrapped value.
- `dwell` and `blank` are sampled only when a phase is entered. Changing them mid-phase does not affect the running phase.
- **Stop:** `stop` in any state forces IDLE on the next edge with `ena` = 0 and `addr` = 0. No `done` pulse is generated. If `start` and `stop` are asserted together, `stop` wins.
- `start` while busy is ignored.
- `ena` is never high in the same cycle that `addr` changes. Exception: back-to-back channels with `blank` = 0, where `addr` changes while `ena` stays 1.

## Timing
- If `start` is sampled at edge T, then `busy` = 1, `ena` = 1 and `addr` = first channel are visible after T.
- Each channel occupies exactly max(`dwell`, 1) + `blank` cycles.
- One full sweep takes M × (max(`dwell`, 1) + `blank`) cycles.
- `done` is asserted in the cycle after the last BLANK cycle, coincident with `busy` falling. When `blank` = 0, it follows the last ACTIVE cycle instead.
- `stop` is sampled at edge T; `ena` = 0 and `busy` = 0 are visible after T.
- Asserting reset mid-scan immediately returns all outputs to their reset values, without waiting for a clock edge.

## Configuration
- `SCAN_SEQ_SKIP_EN` defined:
  - The `skip_mask` port exists.
  - "First", "next" and "last" channel refer to unmasked channels only, searched in ascending index order.
  - `wrap` pulses when the next selected index is ≤ the current index.
  - `skip_mask` is sampled at each advance.
  - If all bits are set, `start` is ignored. A running scan whose mask becomes all-ones goes to IDLE at the next advance, and pulses `done` if one-shot is latched.
- `SCAN_SEQ_SKIP_EN` not defined:
  - No `skip_mask` port.
  - All M channels are visited in order 0..M-1.

## Test plan
- **Continuous scan.** N=2, M=3, `dwell`=4, `blank`=2, `one_shot`=0, pulse `start`.
  - Required: `addr` sequence 0,1,2,0,…
  - Required: `ena` high for 4 cycles and low for 2 cycles per channel.
  - Required: `wrap` pulses every 18 cycles.
- **One-shot sweep.** `dwell`=1, `blank`=0, `one_shot`=1, pulse `start`.
  - Required: `ena` continuously high for 3 cycles.
  - Required: `done` pulses on cycle 4, with `busy` = 0 and `addr` = 0 from then on.
- **Zero dwell.** `dwell`=0, `blank`=1.
  - Required: ACTIVE lasts 1 cycle per channel; period 2 cycles per channel.
- **Stop mid-scan.** Assert `stop` in the second ACTIVE cycle of channel 1.
  - Required: the next cycle has `ena` = 0, `addr` = 0, `busy` = 0 and no `done` pulse.
  - Also: `start` and `stop` asserted together while idle leaves the block idle.
- **Reset and ignored start.**
  - Asserting `rst` asynchronously during BLANK immediately clears all outputs.
  - `start` pulsed while busy leaves the sequence unchanged.
- **Skip mask** (`SCAN_SEQ_SKIP_EN` defined).
  - `skip_mask`=3'b010 gives the `addr` sequence 0,2,0,2 with `wrap` on each 2→0 transition.
  - `skip_mask`=3'b111 with `start` leaves `busy` = 0.
